// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
package uart_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Tick positions within a bit: three mid-bit samples and the wrap point.
    localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(7);
    localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(8);
    localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(9);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(15);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_16x_if.sv
// Downstream valid/ready byte interface of the UART receiver.
interface uart_rx_16x_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/rx_sync.sv
// rx line synchroniser and rising-edge tick detect on the 16x baud enable.
module rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_16bd,
    input  logic rx,
    output logic rx_s,
    output logic tick_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   clk_16bd_q, clk_16bd_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        clk_16bd_d = clk_16bd;
    end

    // Synchroniser resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '1;
            clk_16bd_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            clk_16bd_q <= clk_16bd_d;
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign tick_c = clk_16bd & ~clk_16bd_q;

endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver: 16x oversampled, majority-vote bit decode, one-entry output register.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_16bd,
    input  logic          rx,
    uart_rx_16x_if.master rx_if,
    output logic          busy,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun
);

    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic        PAR_ON = (PARITY_EN != 0);
    localparam logic        ODD    = (PARITY_ODD != 0);

    logic rx_s;
    logic tick_c;

    rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_16bd (clk_16bd),
        .rx       (rx),
        .rx_s     (rx_s),
        .tick_c   (tick_c)
    );

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   armed_q, armed_d;
    logic [1:0]             samp_q, samp_d;
    logic [BIT_W-1:0]       bits_q, bits_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   pmis_q, pmis_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;
    logic                   ovr_q, ovr_d;

    logic maj_c;
    logic decide_c;
    logic wrap_c;
    logic deliver_c;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        samp_d    = samp_q;
        bits_d    = bits_q;
        shreg_d   = shreg_q;
        pmis_d    = pmis_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        ovr_d     = 1'b0;
        deliver_c = 1'b0;

        maj_c    = maj3(samp_q[1], samp_q[0], rx_s);
        decide_c = tick_c && (cnt_q == SAMPLE_C);
        wrap_c   = tick_c && (cnt_q == CNT_LAST);

        // Bit-time counter and the two early samples of the majority vote.
        if (state_q != IDLE && tick_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == SAMPLE_A) samp_d[1] = rx_s;
            if (cnt_q == SAMPLE_B) samp_d[0] = rx_s;
        end

        case (state_q)
            IDLE: begin
                if (rx_s) armed_d = 1'b1;
                if (tick_c && armed_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (decide_c && maj_c) begin
                    state_d = IDLE;
                end else if (wrap_c) begin
                    state_d = DATA;
                    bits_d  = '0;
                    pmis_d  = 1'b0;
                end
            end
            DATA: begin
                if (decide_c) begin
                    shreg_d = {maj_c, shreg_q[DATA_BITS-1:1]};
                    bits_d  = bits_q + BIT_W'(1);
                end
                if (wrap_c && bits_q == BIT_W'(DATA_BITS)) begin
                    state_d = PAR_ON ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decide_c) pmis_d = maj_c ^ (^shreg_q) ^ ODD;
                if (wrap_c) state_d = STOP;
            end
            STOP: begin
                // Finish at mid stop bit so the next start edge is not missed.
                if (decide_c) begin
                    state_d = IDLE;
                    if (!maj_c)      ferr_d    = 1'b1;
                    else if (pmis_q) perr_d    = 1'b1;
                    else             deliver_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
        if (deliver_c) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            samp_q  <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            pmis_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            samp_q  <= samp_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            pmis_q  <= pmis_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign busy           = busy_q;
    assign frame_err      = ferr_q;
    assign parity_err     = perr_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x: an 8N1 receiver and an even-parity receiver.
module tb_uart_rx_16x;

    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;
    localparam int EV_OVR  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_16bd = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    int unsigned div = 4;
    int unsigned phase = 0;

    logic busy_a, ferr_a, perr_a, ovr_a;
    logic busy_b, ferr_b, perr_b, ovr_b;

    logic [7:0] exp_data_a[$];
    logic [7:0] exp_data_b[$];
    int         exp_evt_a[$];
    int         exp_evt_b[$];
    int         vectors = 0;
    int         miscompares = 0;

    uart_rx_16x_if #(.DATA_BITS(8)) if_a ();
    uart_rx_16x_if #(.DATA_BITS(8)) if_b ();

    uart_rx_16x #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst_n), .clk_16bd(clk_16bd), .rx(rx_a), .rx_if(if_a),
        .busy(busy_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a)
    );

    uart_rx_16x #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(3)) u_b (
        .clk(clk), .rst(rst_n), .clk_16bd(clk_16bd), .rx(rx_b), .rx_if(if_b),
        .busy(busy_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    // 16x baud enable: square wave of period div clocks.
    always @(negedge clk) begin
        if (phase + 1 >= div) phase = 0;
        else                  phase = phase + 1;
        clk_16bd = (phase < div / 2);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_data(input int side, input logic [7:0] got);
        logic [7:0] e;
        vectors++;
        if ((side == 0 ? exp_data_a.size() : exp_data_b.size()) == 0) begin
            miscompares++;
            $display("FAIL data_%0d: got %02h, no byte expected", side, got);
        end else begin
            e = (side == 0) ? exp_data_a.pop_front() : exp_data_b.pop_front();
            if (got !== e) begin
                miscompares++;
                $display("FAIL data_%0d: got %02h expected %02h", side, got, e);
            end
        end
    endtask

    task automatic chk_evt(input int side, input int kind);
        int e;
        vectors++;
        if ((side == 0 ? exp_evt_a.size() : exp_evt_b.size()) == 0) begin
            miscompares++;
            $display("FAIL evt_%0d: got pulse kind %0d, none expected", side, kind);
        end else begin
            e = (side == 0) ? exp_evt_a.pop_front() : exp_evt_b.pop_front();
            if (kind != e) begin
                miscompares++;
                $display("FAIL evt_%0d: got pulse kind %0d expected %0d", side, kind, e);
            end
        end
    endtask

    // Monitor: every handshake and every error pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_a.rx_valid && if_a.rx_ready) chk_data(0, if_a.rx_data);
            if (if_b.rx_valid && if_b.rx_ready) chk_data(1, if_b.rx_data);
            if (ferr_a) chk_evt(0, EV_FERR);
            if (perr_a) chk_evt(0, EV_PERR);
            if (ovr_a)  chk_evt(0, EV_OVR);
            if (ferr_b) chk_evt(1, EV_FERR);
            if (perr_b) chk_evt(1, EV_PERR);
            if (ovr_b)  chk_evt(1, EV_OVR);
        end
    end

    // Drive n line bits, bits[0] first, each lasting one bit time.
    task automatic send_bits(input int side, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (side == 0) rx_a = bits[i];
            else           rx_b = bits[i];
            repeat (16 * div) @(negedge clk);
        end
    endtask

    // Reference model: frame outcome from the line-level frame content.
    task automatic expect_a(input logic [7:0] d, input logic stop);
        if (!stop) exp_evt_a.push_back(EV_FERR);
        else       exp_data_a.push_back(d);
    endtask

    task automatic expect_b(input logic [7:0] d, input logic par, input logic stop);
        if (!stop)           exp_evt_b.push_back(EV_FERR);
        else if (par != ^d)  exp_evt_b.push_back(EV_PERR);
        else                 exp_data_b.push_back(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       st;
        logic       par;
        bit         seen;

        if_a.rx_ready = 1'b1;
        if_b.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", if_a.rx_valid, 0);
        check("rst_data", if_a.rx_data, 0);
        check("rst_busy", busy_a, 0);
        check("rst_errs", {ferr_a, perr_a, ovr_a}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Basic 8N1 frame; rx_valid must last exactly one clock.
        expect_a(8'hA5, 1'b1);
        fork
            send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
            begin
                seen = 1'b0;
                for (int i = 0; i < 16 * 12 * 4; i++) begin
                    @(negedge clk);
                    if (if_a.rx_valid) begin seen = 1'b1; break; end
                end
                check("a5_valid_seen", seen, 1);
                @(negedge clk);
                check("a5_valid_1clk", if_a.rx_valid, 0);
            end
        join

        // False start: short low pulse.
        rx_a = 1'b0;
        repeat (3 * div) @(negedge clk);
        check("fs_busy_hi", busy_a, 1);
        repeat (2 * div) @(negedge clk);
        rx_a = 1'b1;
        repeat (10 * div) @(negedge clk);
        check("fs_busy_lo", busy_a, 0);
        check("fs_valid", if_a.rx_valid, 0);

        // Framing error followed by a held-low break.
        expect_a(8'h3C, 1'b0);
        send_bits(0, {1'b0, 8'h3C, 1'b0}, 10);
        repeat (16 * div * 25) @(negedge clk);
        check("brk_busy", busy_a, 0);
        rx_a = 1'b1;
        repeat (32 * div) @(negedge clk);
        check("brk_valid", if_a.rx_valid, 0);

        // Overrun with rx_ready low.
        @(posedge clk); #2 if_a.rx_ready = 1'b0;
        exp_data_a.push_back(8'h11);
        exp_evt_a.push_back(EV_OVR);
        send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        send_bits(0, {1'b1, 8'h22, 1'b0}, 10);
        repeat (32 * div) @(negedge clk);
        check("ovr_data_held", if_a.rx_data, 8'h11);
        check("ovr_valid_held", if_a.rx_valid, 1);
        @(posedge clk); #2 if_a.rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", if_a.rx_valid, 0);

        // Even parity: 0x03 needs parity bit 0.
        expect_b(8'h03, 1'b1, 1'b1);
        send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        expect_b(8'h03, 1'b0, 1'b1);
        send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
        repeat (32 * div) @(negedge clk);
        check("par_data", if_b.rx_data, 8'h03);

        // Reset in the middle of data bit 4.
        send_bits(0, {1'b1, 8'hFF, 1'b0}, 5);
        repeat (8 * div) @(negedge clk);
        check("mid_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_valid", if_a.rx_valid, 0);
        check("mid_rst_data", if_a.rx_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (32 * div) @(negedge clk);
        expect_a(8'h5A, 1'b1);
        send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        repeat (16 * div) @(negedge clk);

        // Random frames at varying baud on both receivers.
        for (int k = 0; k < 20; k++) begin
            div = 4 + $urandom_range(0, 2);
            repeat (2 * div) @(negedge clk);
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) begin
                expect_a(d, st);
                send_bits(0, {st, d, 1'b0}, 10);
                rx_a = 1'b1;
            end else begin
                par = 1'($urandom_range(0, 1));
                expect_b(d, par, st);
                send_bits(1, {st, par, d, 1'b0}, 11);
                rx_b = 1'b1;
            end
            if (!st) repeat (32 * div) @(negedge clk);
        end
        repeat (32 * div) @(negedge clk);

        check("left_data_a", exp_data_a.size(), 0);
        check("left_data_b", exp_data_b.size(), 0);
        check("left_evt_a", exp_evt_a.size(), 0);
        check("left_evt_b", exp_evt_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
